// File: rtl/mux_4_to_1_if.sv
// Select/data/result bundle for mux_4_to_1; chg_cnt exists only when MUX_4_TO_1_STATS_EN is defined.
interface mux_4_to_1_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_q_valid;
  logic             sel_chg;
`ifdef MUX_4_TO_1_STATS_EN
  logic [15:0]      chg_cnt;
`endif

`ifdef MUX_4_TO_1_STATS_EN
  modport master (output en, s0, s1, i0, i1, i2, i3,
                  input  y, y_q, y_q_valid, sel_chg, chg_cnt);
  modport slave  (input  en, s0, s1, i0, i1, i2, i3,
                  output y, y_q, y_q_valid, sel_chg, chg_cnt);
`else
  modport master (output en, s0, s1, i0, i1, i2, i3,
                  input  y, y_q, y_q_valid, sel_chg);
  modport slave  (input  en, s0, s1, i0, i1, i2, i3,
                  output y, y_q, y_q_valid, sel_chg);
`endif
endinterface

// File: rtl/mux_4_to_1.sv
// 4:1 mux with combinational y plus an enabled registered copy and select-change pulse; optional chg_cnt under MUX_4_TO_1_STATS_EN.
// Latency: y 0 cycles, y_q and sel_chg 1 cycle. No backpressure: en gates capture, holding state when low.
module mux_4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  mux_4_to_1_if.slave  bus
);

  logic [1:0]       sel;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] y_mux;
  logic [WIDTH-1:0] y_q;
  logic             y_q_valid;
  logic             sel_chg;

  assign sel = {bus.s0, bus.s1};

  // Unknown select values fall through to i0.
  always_comb begin
    y_mux = bus.i0;
    case (sel)
      2'b01:   y_mux = bus.i1;
      2'b10:   y_mux = bus.i2;
      2'b11:   y_mux = bus.i3;
      default: y_mux = bus.i0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_q_valid <= 1'b0;
      sel_q     <= 2'b00;
      sel_chg   <= 1'b0;
    end else if (bus.en) begin
      y_q       <= y_mux;
      y_q_valid <= 1'b1;
      sel_q     <= sel;
      // No reference index exists until the first capture after reset.
      sel_chg   <= y_q_valid && (sel != sel_q);
    end else begin
      sel_chg   <= 1'b0;
    end
  end

  assign bus.y         = y_mux;
  assign bus.y_q       = y_q;
  assign bus.y_q_valid = y_q_valid;
  assign bus.sel_chg   = sel_chg;

`ifdef MUX_4_TO_1_STATS_EN
  logic [15:0] chg_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_cnt <= 16'h0000;
    end else if (sel_chg && (chg_cnt != 16'hFFFF)) begin
      chg_cnt <= chg_cnt + 16'h0001;
    end
  end

  assign bus.chg_cnt = chg_cnt;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// Bench for mux_4_to_1: directed cases plus random traffic against a cycle-level reference model.
module tb_mux_4_to_1;

  logic clk;
  logic rst;
  logic clk_on;

  int checks;
  int errors;

  mux_4_to_1_if #(.WIDTH(8)) bus ();
  mux_4_to_1_if #(.WIDTH(1)) bus1 ();

  mux_4_to_1 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux_4_to_1 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial begin
    clk = 1'b0;
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [7:0] m_q;
  logic       m_v;
  logic       m_chg;
  logic [1:0] m_idx;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] sel,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] din [4];
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    rst    = r;
    bus.en = e;
    bus.s0 = sel[1];
    bus.s1 = sel[0];
    bus.i0 = a; bus.i1 = b; bus.i2 = c; bus.i3 = d;
    #1;
    check("y_comb", {24'h0, bus.y}, {24'h0, din[sel]});
    if (r) begin
      m_q = 8'h00; m_v = 1'b0; m_chg = 1'b0; m_idx = 2'b00; m_cnt = 0;
    end else begin
      if (m_chg && m_cnt < 65535) m_cnt++;
      if (e) begin
        m_chg = m_v && (sel != m_idx);
        m_q   = din[sel];
        m_v   = 1'b1;
        m_idx = sel;
      end else begin
        m_chg = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("y_q", {24'h0, bus.y_q}, {24'h0, m_q});
    check("y_q_valid", {31'h0, bus.y_q_valid}, {31'h0, m_v});
    check("sel_chg", {31'h0, bus.sel_chg}, {31'h0, m_chg});
`ifdef MUX_4_TO_1_STATS_EN
    check("chg_cnt", {16'h0, bus.chg_cnt}, m_cnt);
`endif
  endtask

  initial begin
    logic [7:0] r8 [4];
    checks = 0;
    errors = 0;
    clk_on = 1'b0;
    rst    = 1'b1;
    bus.en = 1'b0; bus.s0 = 1'b0; bus.s1 = 1'b0;
    bus.i0 = '0; bus.i1 = '0; bus.i2 = '0; bus.i3 = '0;
    bus1.en = 1'b0;

    // One-hot WIDTH=1 drive with the clock stopped
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ks;
      ks = 2'(k);
      bus1.s0 = ks[1];
      bus1.s1 = ks[0];
      bus1.i0 = (k == 0); bus1.i1 = (k == 1);
      bus1.i2 = (k == 2); bus1.i3 = (k == 3);
      #10;
      check("onehot_y", {31'h0, bus1.y}, 32'h1);
    end

    // WIDTH=8 select sweep, combinational only
    bus.i0 = 8'h11; bus.i1 = 8'h22; bus.i2 = 8'h33; bus.i3 = 8'h44;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ks;
      ks = 2'(k);
      bus.s0 = ks[1];
      bus.s1 = ks[0];
      #10;
      check("sweep_y", {24'h0, bus.y}, 32'h11 * (k + 1));
    end

    clk_on = 1'b1;
    m_q = 8'h00; m_v = 1'b0; m_chg = 1'b0; m_idx = 2'b00; m_cnt = 0;

    // Two reset cycles, then first capture of select 10
    cycle(1'b1, 1'b1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
    cycle(1'b1, 1'b1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
    check("rst_y_q", {24'h0, bus.y_q}, 32'h0);
    cycle(1'b0, 1'b1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
    check("first_cap_y_q", {24'h0, bus.y_q}, 32'h33);
    check("first_cap_chg", {31'h0, bus.sel_chg}, 32'h0);

    // Select sequence 00,00,11,11,01 with data-only changes in between
    cycle(1'b0, 1'b1, 2'b00, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    cycle(1'b0, 1'b1, 2'b00, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    check("same_sel_chg", {31'h0, bus.sel_chg}, 32'h0);
    cycle(1'b0, 1'b1, 2'b11, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    check("to_11_chg", {31'h0, bus.sel_chg}, 32'h1);
    cycle(1'b0, 1'b1, 2'b11, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    cycle(1'b0, 1'b1, 2'b01, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    check("to_01_chg", {31'h0, bus.sel_chg}, 32'h1);

    // en low with select toggling: state holds
    cycle(1'b0, 1'b0, 2'b10, 8'hF0, 8'hF1, 8'hF2, 8'hF3);
    cycle(1'b0, 1'b0, 2'b00, 8'hF0, 8'hF1, 8'hF2, 8'hF3);
    check("hold_y_q", {24'h0, bus.y_q}, 32'hE1);

    // Reset colliding with an enabled capture of a new select
    cycle(1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 8'h03, 8'h04);
    check("rst_vs_en_y_q", {24'h0, bus.y_q}, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) r8[k] = 8'($urandom);
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), r8[0], r8[1], r8[2], r8[3]);
    end

`ifdef MUX_4_TO_1_STATS_EN
    cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 70000; n++) begin
      cycle(1'b0, 1'b1, (n % 2 == 0) ? 2'b00 : 2'b11, 8'h5A, 8'h00, 8'h00, 8'hA5);
    end
    check("cnt_saturated", {16'h0, bus.chg_cnt}, 32'hFFFF);
    cycle(1'b0, 1'b1, 2'b00, 8'h5A, 8'h00, 8'h00, 8'hA5);
    check("cnt_no_wrap", {16'h0, bus.chg_cnt}, 32'hFFFF);
    cycle(1'b1, 1'b1, 2'b11, 8'h5A, 8'h00, 8'h00, 8'hA5);
    check("cnt_reset", {16'h0, bus.chg_cnt}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4_to_1.md
MUX_4_TO_1 -- requirements
Module: mux_4_to_1

Interface
REQ-001 Parameter WIDTH, default 1, data width of every data input and output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high, sampled on rising clk.
REQ-004 en  input  1  registered-stage update enable.
REQ-005 s0  input  1  select bit, MSB of select index.
REQ-006 s1  input  1  select bit, LSB of select index.
REQ-007 i0, i1, i2, i3  input  WIDTH each  data inputs.
REQ-008 y  output  WIDTH  combinational mux result.
REQ-009 y_q  output  WIDTH  registered mux result.
REQ-010 y_q_valid  output  1  y_q holds a value captured since reset.
REQ-011 sel_chg  output  1  one-cycle pulse: select index differs from its value at the previous enabled capture.
REQ-012 chg_cnt  output  16  select-change count; present only when MUX_4_TO_1_STATS_EN is defined.

Function
REQ-013 Select index SHALL be {s0, s1}: 00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3.
REQ-014 y SHALL be purely combinational from s0, s1, i0..i3: zero latency, independent of clk, rst and en.
REQ-015 Any X/Z on s0 or s1 SHALL NOT be relied on; synthesis full-case, with the default branch driving i0.
REQ-016 On a rising clk with rst=0 and en=1, y_q SHALL load the y value present before the edge, and y_q_valid SHALL be set to 1.
REQ-017 With en=0, y_q, y_q_valid and the stored select index SHALL hold.
REQ-018 The stored select index SHALL update only on enabled captures.
REQ-019 sel_chg SHALL be 1 for exactly the cycle after an enabled capture whose select index differs from the stored index, and 0 otherwise.
REQ-020 The first enabled capture after reset SHALL NOT assert sel_chg, because y_q_valid was 0.
REQ-021 Data-only changes (select unchanged) SHALL NOT assert sel_chg.
REQ-022 Latency: y is 0 cycles, y_q is 1 cycle, sel_chg is 1 cycle.

Reset
REQ-023 While rst=1 at a rising edge: y_q=0, y_q_valid=0, sel_chg=0, stored select index=00, chg_cnt=0.
REQ-024 rst SHALL take priority over en.
REQ-025 An assertion of rst mid-operation SHALL discard the pending capture in that cycle.
REQ-026 y SHALL remain functional during reset.

Configuration
REQ-027 With MUX_4_TO_1_STATS_EN defined, chg_cnt SHALL increment by 1 on every cycle in which sel_chg is asserted.
REQ-028 chg_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 chg_cnt SHALL reset to 0 under rst.
REQ-030 Without MUX_4_TO_1_STATS_EN, the chg_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=1, no clock edges, one-hot drive: (s0,s1)=(0,0), i0=1, others 0 -> y=1; (0,1), i1=1 -> y=1; (1,0), i2=1 -> y=1; (1,1), i3=1 -> y=1; each checked 10 ns after the change.
REQ-032 WIDTH=8, inputs i0=8'h11, i1=8'h22, i2=8'h33, i3=8'h44; sweep all 4 selects -> y = 11, 22, 33, 44 respectively.
REQ-033 rst=1 for 2 cycles, then en=1 with select 10 -> y_q=0 and y_q_valid=0 during reset; y_q=i2 one cycle after release; sel_chg=0 on that first capture.
REQ-034 en=1, select sequence 00,00,11,11,01 -> sel_chg pulses in the cycles after the 11 capture and after the 01 capture only; with en=0 and a select toggle -> y_q holds and sel_chg=0.
REQ-035 Stats build: force 70000 select changes -> chg_cnt=16'hFFFF and remains there; rst=1 -> chg_cnt=0 on the next edge.
REQ-036 Assert rst in the same cycle as en=1 with a new select -> y_q=0 and sel_chg=0 after the edge.
